monster_hp_bar: RTL
===================

Name: monster_hp_bar

Overview:
- Sequential sprite generator for the monster's health bar.
- Sits directly upstream of the frame object multiplexer and drives its monster-HP drawing-request/RGB input pair.
- Holds the monster HP counter, applies hit damage, runs a hit-flash animation and low-HP colouring, and reports monster death.
- Registered output timing matches the other sprite stages feeding the multiplexer.

Parameters:
- MAX_HP, 16: starting and maximum HP; 1..31.
- BAR_X, 11'd200: left column of the bar's outer border.
- BAR_Y, 11'd16: top row of the bar's outer border.
- SEG_W, 8: pixels per HP unit; must be a power of two.
- BAR_H, 8: interior height in pixels.
- FLASH_FRAMES, 8: frames the flash animation lasts after a hit.
- LOW_THRESHOLD, 4: HP at or below this value uses LOW_COLOR.
- FULL_COLOR, 8'h1C: RGB332 fill colour when HP > LOW_THRESHOLD.
- LOW_COLOR, 8'hE0: RGB332 fill colour when HP <= LOW_THRESHOLD.
- FLASH_COLOR, 8'hFF: fill colour during the flash "on" phase.
- BORDER_COLOR, 8'hFF: 1-px border colour.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- reset  in  1  asynchronous, active-high reset.
- startOfFrame  in  1  one-cycle pulse at the start of each VGA frame.
- pixelX  in  11  current pixel column.
- pixelY  in  11  current pixel row.
- hit  in  1  one-cycle pulse: the monster was struck.
- damage  in  4  HP to subtract, sampled when hit=1.
- restart  in  1  one-cycle pulse: restore full HP.
- monsterHPDrawingRequest  out  1  current pixel belongs to the bar.
- monsterHPRGB  out  8  colour for the current pixel.
- hp  out  5  live HP value.
- monsterDead  out  1  level; high while HP = 0.

Behaviour:
- Reset (asynchronous, active-high) sets:
  - hp=MAX_HP, hp_disp=MAX_HP, state=ALIVE, flash_cnt=0.
  - monsterHPDrawingRequest=0, monsterHPRGB=8'h00, monsterDead=0.
- FSM states: ALIVE, FLASH, DEAD.
  - ALIVE, hit with damage≠0 and hp-damage>0 -> FLASH; flash_cnt<=FLASH_FRAMES.
  - ALIVE or FLASH, hit with damage>=hp -> DEAD; hp<=0, saturating (never wraps).
  - FLASH: flash_cnt decrements on each startOfFrame. When a decrement would leave 0 -> ALIVE.
  - FLASH, non-lethal hit -> reload flash_cnt=FLASH_FRAMES and stay in FLASH.
  - DEAD: hit ignored; only restart or reset leaves this state.
  - hit with damage=0 is ignored in every state.
- restart, any state -> ALIVE, hp=MAX_HP, flash_cnt=0. Takes priority over a same-cycle hit.
- hp updates one cycle after hit. monsterDead is registered and equals (state==DEAD).
- Display latching: hp_disp<=hp on startOfFrame only, so the bar never tears mid-frame.
  - hit and startOfFrame in the same cycle: hp_disp takes the pre-hit hp; the new value shows next frame.
- Geometry:
  - Outer box: x in [BAR_X, BAR_X+MAX_HP*SEG_W+1], y in [BAR_Y, BAR_Y+BAR_H+1], inclusive. Unsigned compares.
  - Border: pixels on the outer box edges -> request=1, RGB=BORDER_COLOR.
  - Interior: seg=(pixelX-BAR_X-1)>>log2(SEG_W).
    - seg < hp_disp -> request=1, RGB=fill.
    - otherwise request=0 (transparent), RGB=8'h00.
- Fill colour:
  - state==FLASH and flash_cnt[1]==1 -> FLASH_COLOR.
  - else hp_disp<=LOW_THRESHOLD -> LOW_COLOR.
  - else FULL_COLOR.
- DEAD: border is still drawn; the interior is fully transparent (hp_disp=0 after the next frame).
- Outside the outer box: request=0, RGB=8'h00.
- Latency: the drawing outputs are registered, exactly 1 clk after pixelX/pixelY.
- Reset asserted mid-frame: outputs clear immediately; the bar redraws full from the next pixel after release.

Test Plan:
- Reset released, startOfFrame, scan row BAR_Y+1 -> x=200 border 8'hFF. x=201..328 request=1 with 8'h1C. x=329 border. x=330 request=0. Each output 1 clk after its coordinate.
- hit, damage=3, from hp=16 -> hp=13 next cycle, state FLASH. Over the next 8 frames the fill alternates 8'hFF/8'h1C per flash_cnt[1]. Then ALIVE. Interior x>=201+13*8=305 is transparent.
- Hits to hp=4 -> fill 8'hE0 from the next frame. hit, damage=15 -> hp=0, monsterDead=1. A further hit leaves hp=0 (no wrap).
- restart and hit (damage=5) in the same cycle while DEAD -> hp=16, monsterDead=0, state ALIVE.
- hit coincident with startOfFrame at hp=16, damage=2 -> this frame shows 16 segments, the next frame shows 14.
- Reset pulse mid-scan while hp=5 -> outputs 0 immediately. After release: hp=16, full green bar on the next frame.

Source files
------------

// File: rtl/monster_hp_bar.sv
// Monster health-bar sprite: HP counter, hit/flash/death FSM and a registered bar renderer.
// The bar length is frozen per frame (hp_disp) so the picture never tears mid-scan.
module monster_hp_bar #(
    parameter int          MAX_HP        = 16,
    parameter logic [10:0] BAR_X         = 11'd200,
    parameter logic [10:0] BAR_Y         = 11'd16,
    parameter int          SEG_W         = 8,
    parameter int          BAR_H         = 8,
    parameter int          FLASH_FRAMES  = 8,
    parameter int          LOW_THRESHOLD = 4,
    parameter logic [7:0]  FULL_COLOR    = 8'h1C,
    parameter logic [7:0]  LOW_COLOR     = 8'hE0,
    parameter logic [7:0]  FLASH_COLOR   = 8'hFF,
    parameter logic [7:0]  BORDER_COLOR  = 8'hFF
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        startOfFrame,
    input  logic [10:0] pixelX,
    input  logic [10:0] pixelY,
    input  logic        hit,
    input  logic [3:0]  damage,
    input  logic        restart,
    output logic        monsterHPDrawingRequest,
    output logic [7:0]  monsterHPRGB,
    output logic [4:0]  hp,
    output logic        monsterDead
);

    localparam int               SEG_SHIFT = $clog2(SEG_W);
    localparam int               FW        = $clog2(FLASH_FRAMES + 1);
    localparam logic [10:0]      X_END     = 11'(int'(BAR_X) + MAX_HP * SEG_W + 1);
    localparam logic [10:0]      Y_END     = 11'(int'(BAR_Y) + BAR_H + 1);
    localparam logic [4:0]       HP_FULL   = 5'(MAX_HP);
    localparam logic [4:0]       HP_LOW    = 5'(LOW_THRESHOLD);
    localparam logic [FW-1:0]    FL_LOAD   = FW'(FLASH_FRAMES);
    localparam logic [FW-1:0]    FL_ONE    = FW'(1);

    typedef enum logic [1:0] {ALIVE, FLASH, DEAD} state_t;

    state_t        state, state_nx;
    logic [4:0]    hp_nx, hp_disp;
    logic [FW-1:0] flash_cnt, flash_nx;
    logic          hit_ok, lethal;

    assign hit_ok = hit && (damage != 4'd0) && (state != DEAD);
    assign lethal = {1'b0, damage} >= hp;

    always_comb begin
        state_nx = state;
        hp_nx    = hp;
        flash_nx = flash_cnt;
        if (restart) begin
            state_nx = ALIVE;
            hp_nx    = HP_FULL;
            flash_nx = '0;
        end else if (hit_ok) begin
            if (lethal) begin
                state_nx = DEAD;
                hp_nx    = 5'd0;
                flash_nx = '0;
            end else begin
                state_nx = FLASH;
                hp_nx    = hp - {1'b0, damage};
                flash_nx = FL_LOAD;
            end
        end else if (state == FLASH && startOfFrame) begin
            // The frame that would take the counter to zero ends the animation.
            if (flash_cnt <= FL_ONE) begin
                state_nx = ALIVE;
                flash_nx = '0;
            end else begin
                flash_nx = flash_cnt - FL_ONE;
            end
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state       <= ALIVE;
            hp          <= HP_FULL;
            hp_disp     <= HP_FULL;
            flash_cnt   <= '0;
            monsterDead <= 1'b0;
        end else begin
            state       <= state_nx;
            hp          <= hp_nx;
            flash_cnt   <= flash_nx;
            monsterDead <= (state_nx == DEAD);
            if (startOfFrame)
                hp_disp <= hp;
        end
    end

    // ---- stage p0: pixel classification from the incoming coordinate ----
    logic        in_box_p0, border_p0, seg_on_p0, req_p0;
    logic [10:0] seg_p0;
    logic [7:0]  fill_p0, rgb_p0;

    assign in_box_p0 = (pixelX >= BAR_X) && (pixelX <= X_END) &&
                       (pixelY >= BAR_Y) && (pixelY <= Y_END);
    assign border_p0 = in_box_p0 && ((pixelX == BAR_X) || (pixelX == X_END) ||
                                     (pixelY == BAR_Y) || (pixelY == Y_END));
    assign seg_p0    = (pixelX - BAR_X - 11'd1) >> SEG_SHIFT;
    assign seg_on_p0 = seg_p0 < {6'd0, hp_disp};

    always_comb begin
        fill_p0 = FULL_COLOR;
        if (state == FLASH && flash_cnt[1])
            fill_p0 = FLASH_COLOR;
        else if (hp_disp <= HP_LOW)
            fill_p0 = LOW_COLOR;
    end

    always_comb begin
        req_p0 = 1'b0;
        rgb_p0 = 8'h00;
        if (border_p0) begin
            req_p0 = 1'b1;
            rgb_p0 = BORDER_COLOR;
        end else if (in_box_p0 && seg_on_p0) begin
            req_p0 = 1'b1;
            rgb_p0 = fill_p0;
        end
    end

    // ---- stage p1: registered drawing outputs ----
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            monsterHPDrawingRequest <= 1'b0;
            monsterHPRGB            <= 8'h00;
        end else begin
            monsterHPDrawingRequest <= req_p0;
            monsterHPRGB            <= rgb_p0;
        end
    end

endmodule
